// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared types and constants for the FIFO access controller
// Contents:
//   rd_state_t     : read-side FSM states.
//   FIFO_DEPTH     : entries in the shared FIFO. The controller trusts the FIFO's
//                    flags and keeps no occupancy count of its own.
//   DEFAULT_DATA_W : default data width; it must match the FIFO word width.
package fifo_ctrl_pkg;

  localparam int FIFO_DEPTH     = 8;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_HOLD = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fifo_access_ctrl_rr_arbiter.sv
// rtl/fifo_access_ctrl_rr_arbiter.sv - round-robin arbiter owning the rotation pointer
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset.
//   req         : request vector, one bit per producer.
//   advance     : high when the current grant is consumed this cycle.
//   grant       : one-hot grant; all zeros when nothing is requested.
//   grant_idx   : binary index of the granted producer.
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // Search starts at rr_ptr_q and wraps; the first requester found wins.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // The pointer only moves past a winner that was actually accepted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      rr_ptr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/fifo_access_ctrl.sv
// rtl/fifo_access_ctrl.sv - push/pop scheduler in front of a shared 8x8 FIFO
// Ports:
//   clk, reset            : clock and asynchronous active-low reset.
//   req_valid/req_data    : N_REQ producer streams; slice i is [i*DATA_W +: DATA_W].
//   req_ready             : one-hot acceptance of the producer pushed this cycle.
//   fifo_push/fifo_din    : FIFO write strobe and data.
//   fifo_pop              : FIFO read strobe; fifo_dout is valid the cycle after.
//   fifo_full/fifo_empty  : FIFO flags, used as-is.
//   out_valid/out_data    : registered output stream, accepted with out_ready.
// Push and pop are never issued together; the FIFO cannot update its count twice.
module fifo_access_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    fifo_push,
  output logic [DATA_W-1:0]       fifo_din,
  output logic                    fifo_pop,
  input  logic [DATA_W-1:0]       fifo_dout,
  input  logic                    fifo_full,
  input  logic                    fifo_empty,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grant_idx;
  rd_state_t         rd_state_q;
  logic              turn_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              wr_cand, rd_cand, do_push, do_pop;

  assign wr_cand = (|req_valid) && !fifo_full;
  // A pop may only start when the output register is free or being drained now.
  assign rd_cand = !fifo_empty &&
                   ((rd_state_q == RD_IDLE) || ((rd_state_q == RD_HOLD) && out_ready));

  // On a conflict turn_q picks the side; reset gates the strobes immediately.
  assign do_push = reset && wr_cand && (!rd_cand || !turn_q);
  assign do_pop  = reset && rd_cand && (!wr_cand || turn_q);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (reset),
    .req       (req_valid),
    .advance   (do_push),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign fifo_push = do_push;
  assign fifo_pop  = do_pop;
  assign req_ready = do_push ? grant : '0;
  assign fifo_din  = do_push ? req_data[grant_idx*DATA_W +: DATA_W] : '0;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state_q  <= RD_IDLE;
      turn_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (wr_cand && rd_cand) begin
        turn_q <= !turn_q;
      end
      case (rd_state_q)
        RD_IDLE: begin
          if (do_pop) rd_state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          out_data_q  <= fifo_dout;
          out_valid_q <= 1'b1;
          rd_state_q  <= RD_HOLD;
        end
        RD_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            rd_state_q  <= do_pop ? RD_WAIT : RD_IDLE;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// tb/tb_fifo_access_ctrl.sv - directed self-checking bench for fifo_access_ctrl
module tb_fifo_access_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int N = 2;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_push, fifo_pop;
  logic [W-1:0]   fifo_din, fifo_dout;
  logic           fifo_full, fifo_empty;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_access_ctrl #(.N_REQ(N), .DATA_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_push  (fifo_push),
    .fifo_din   (fifo_din),
    .fifo_pop   (fifo_pop),
    .fifo_dout  (fifo_dout),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready)
  );

  // 8x8 FIFO model sharing the controller's reset.
  logic [W-1:0] mem [8];
  logic [2:0]   wp, rp;
  logic [3:0]   cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0; rp <= '0; cnt <= '0; fifo_dout <= '0;
    end else begin
      if (fifo_push && cnt != 4'd8) begin
        mem[wp] <= fifo_din;
        wp      <= wp + 3'd1;
      end
      if (fifo_pop && cnt != 4'd0) begin
        fifo_dout <= mem[rp];
        rp        <= rp + 3'd1;
      end
      if (fifo_push && !fifo_pop && cnt != 4'd8) cnt <= cnt + 4'd1;
      else if (fifo_pop && !fifo_push && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end

  assign fifo_full  = (cnt == 4'd8);
  assign fifo_empty = (cnt == 4'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Invariants sampled mid-cycle.
  logic         pv = 1'b0;
  logic [W-1:0] pd = '0;
  always @(negedge clk) begin
    if (reset) begin
      chk("inv_no_push_pop", 32'(!(fifo_push && fifo_pop)), 32'd1);
      chk("inv_onehot0", 32'($onehot0(req_ready)), 32'd1);
      chk("inv_push_ready", 32'(fifo_push), 32'(|req_ready));
      if (pv) chk("inv_hold_stable", 32'(out_data), 32'(pd));
    end
    pv = reset && out_valid && !out_ready;
    pd = out_data;
  end

  logic [1:0] rr_tab [15] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10,
                              2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [7:0] drain_tab [9] = '{8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3, 8'hA4, 8'hFF};
  logic       cf_push [11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic       cf_ov   [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] cf_od   [11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'h00, 8'h00, 8'hC1, 8'h00, 8'h00, 8'hC2};

  initial begin
    logic [7:0] n0, n1, exp_din;
    reset = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_push", 32'(fifo_push), 32'd0);
    chk("rst_pop", 32'(fifo_pop), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_state", 32'(dut.rd_state_q), 32'(RD_IDLE));
    chk("rst_rr_ptr", 32'(dut.u_arb.rr_ptr_q), 32'd0);
    cyc(); cyc();
    reset = 1'b1;

    // Single producer, out_ready=1.
    out_ready = 1'b1;
    req_valid = 2'b01; req_data = 16'h0011; #1;
    chk("sp_c0_push", 32'(fifo_push), 32'd1);
    chk("sp_c0_din", 32'(fifo_din), 32'h11);
    chk("sp_c0_rdy", 32'(req_ready), 32'b01);
    cyc();
    req_data = 16'h0022; #1;
    chk("sp_c1_push_conflict", 32'(fifo_push), 32'd1);
    chk("sp_c1_din", 32'(fifo_din), 32'h22);
    chk("sp_c1_pop", 32'(fifo_pop), 32'd0);
    cyc();
    req_data = 16'h0033; #1;
    chk("sp_c2_pop_turn", 32'(fifo_pop), 32'd1);
    chk("sp_c2_rdy", 32'(req_ready), 32'b00);
    cyc();
    #1;
    chk("sp_c3_push", 32'(fifo_push), 32'd1);
    chk("sp_c3_din", 32'(fifo_din), 32'h33);
    chk("sp_c3_ov", 32'(out_valid), 32'd0);
    cyc();
    req_valid = 2'b00; #1;
    chk("sp_c4_ov", 32'(out_valid), 32'd1);
    chk("sp_c4_od", 32'(out_data), 32'h11);
    chk("sp_c4_pop", 32'(fifo_pop), 32'd1);
    cyc();
    #1;
    chk("sp_c5_ov", 32'(out_valid), 32'd0);
    chk("sp_c5_pop_wait", 32'(fifo_pop), 32'd0);
    cyc();
    #1;
    chk("sp_c6_od", 32'(out_data), 32'h22);
    chk("sp_c6_pop", 32'(fifo_pop), 32'd1);
    cyc(); cyc();
    #1;
    chk("sp_c8_ov", 32'(out_valid), 32'd1);
    chk("sp_c8_od", 32'(out_data), 32'h33);
    chk("sp_c8_pop_empty", 32'(fifo_pop), 32'd0);
    cyc();
    #1;
    chk("sp_c9_idle", 32'(dut.rd_state_q), 32'(RD_IDLE));
    reset = 1'b0; #1; reset = 1'b1;
    cyc();

    // Round-robin fill to full, then backpressure on the held word.
    n0 = 8'hA0; n1 = 8'hB0;
    out_ready = 1'b0; req_valid = 2'b11;
    for (int i = 0; i < 15; i++) begin
      req_data = {n1, n0}; #1;
      exp_din = rr_tab[i][0] ? n0 : (rr_tab[i][1] ? n1 : 8'h00);
      chk($sformatf("rr_rdy_%0d", i), 32'(req_ready), 32'(rr_tab[i]));
      chk($sformatf("rr_din_%0d", i), 32'(fifo_din), 32'(exp_din));
      chk($sformatf("rr_pop_%0d", i), 32'(fifo_pop), 32'(i == 2));
      if (i >= 4) begin
        chk($sformatf("bp_ov_%0d", i), 32'(out_valid), 32'd1);
        chk($sformatf("bp_od_%0d", i), 32'(out_data), 32'hA0);
      end
      if (rr_tab[i][0]) n0 = n0 + 8'd1;
      if (rr_tab[i][1]) n1 = n1 + 8'd1;
      cyc();
    end

    // Full edge: req1 waits with 0xFF, pop releases a slot.
    req_valid = 2'b10; req_data = 16'hFF00; out_ready = 1'b1; #1;
    chk("full_pop_same_cycle", 32'(fifo_pop), 32'd1);
    chk("full_no_push", 32'(fifo_push), 32'd0);
    cyc();
    #1;
    chk("full_ff_push", 32'(fifo_push), 32'd1);
    chk("full_ff_rdy", 32'(req_ready), 32'b10);
    chk("full_ff_din", 32'(fifo_din), 32'hFF);
    cyc();
    req_valid = 2'b00;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk($sformatf("drain_ov_%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("drain_od_%0d", k), 32'(out_data), 32'(drain_tab[k]));
      chk($sformatf("drain_pop_%0d", k), 32'(fifo_pop), 32'(k < 8));
      cyc();
      #1;
      chk($sformatf("drain_gap_%0d", k), 32'(fifo_pop), 32'd0);
      cyc();
    end
    #1;
    chk("empty_no_pop", 32'(fifo_pop), 32'd0);
    cyc();

    // Conflict fairness with req0 always valid.
    n0 = 8'hC0; req_valid = 2'b01;
    for (int e = 0; e < 11; e++) begin
      req_data = {8'h00, n0}; #1;
      chk($sformatf("cf_push_%0d", e), 32'(fifo_push), 32'(cf_push[e]));
      chk($sformatf("cf_pop_%0d", e), 32'(fifo_pop), 32'(!cf_push[e]));
      if (cf_push[e]) chk($sformatf("cf_din_%0d", e), 32'(fifo_din), 32'(n0));
      chk($sformatf("cf_ov_%0d", e), 32'(out_valid), 32'(cf_ov[e]));
      if (cf_ov[e]) chk($sformatf("cf_od_%0d", e), 32'(out_data), 32'(cf_od[e]));
      if (cf_push[e]) n0 = n0 + 8'd1;
      cyc();
    end
    req_data = {8'h00, n0}; #1;
    chk("cf_e11_pop", 32'(fifo_pop), 32'd1);
    cyc();

    // Async reset while in RD_WAIT.
    #1;
    chk("ar_state_wait", 32'(dut.rd_state_q), 32'(RD_WAIT));
    chk("ar_push_before", 32'(fifo_push), 32'd1);
    chk("ar_od_before", 32'(out_data), 32'hC2);
    chk("ar_rr_before", 32'(dut.u_arb.rr_ptr_q), 32'd1);
    reset = 1'b0; #1;
    chk("ar_ov", 32'(out_valid), 32'd0);
    chk("ar_od", 32'(out_data), 32'd0);
    chk("ar_push", 32'(fifo_push), 32'd0);
    chk("ar_pop", 32'(fifo_pop), 32'd0);
    chk("ar_rdy", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    cyc();
    reset = 1'b1; #1;
    chk("ar_state_idle", 32'(dut.rd_state_q), 32'(RD_IDLE));
    chk("ar_rr_zero", 32'(dut.u_arb.rr_ptr_q), 32'd0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
